// File: rtl/nrisc_pkg.sv
// nrisc_pkg: opcodes, control states and datapath select encodings shared by the nRisc core and bench.
package nrisc_pkg;
    typedef enum logic [2:0] {
        OP_ADD, OP_SUB, OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_JMP, OP_HALT
    } opcode_t;
    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT, S_FAULT
    } state_t;
    localparam logic [1:0] ALU_ADD = 2'd0;
    localparam logic [1:0] ALU_SUB = 2'd1;
    localparam logic [1:0] ALU_PASS_B = 2'd2;
    localparam logic [1:0] PC_INC = 2'd0;
    localparam logic [1:0] PC_BRANCH = 2'd1;
    localparam logic [1:0] PC_JUMP = 2'd2;
endpackage

// File: rtl/nrisc_control_fsm_if.sv
// nrisc_control_fsm_if: control bus between the nRisc control unit (master) and datapath/memory (slave).
interface nrisc_control_fsm_if #(parameter int RET_W = 8);
    logic [7:0] ir;
    logic zero, mem_ack;
    logic mem_req, mem_we, mem_src, ir_write, pc_write;
    logic [1:0] pc_src;
    logic ext_sel;
    logic [1:0] alu_op;
    logic alu_b_sel, reg_write, wb_src, halted, fault;
    logic [RET_W-1:0] retired;
    modport master (
        input ir, zero, mem_ack,
        output mem_req, mem_we, mem_src, ir_write, pc_write, pc_src, ext_sel,
        output alu_op, alu_b_sel, reg_write, wb_src, halted, fault, retired
    );
    modport slave (
        output ir, zero, mem_ack,
        input mem_req, mem_we, mem_src, ir_write, pc_write, pc_src, ext_sel,
        input alu_op, alu_b_sel, reg_write, wb_src, halted, fault, retired
    );
endinterface

// File: rtl/nrisc_op_decode.sv
// nrisc_op_decode: opcode -> ALU/extender configuration and instruction class flags.
module nrisc_op_decode
    import nrisc_pkg::*;
(
    input  logic [2:0] op,
    output logic [1:0] alu_op,
    output logic       alu_b_sel,
    output logic       ext_sel,
    output logic       is_mem,
    output logic       is_store,
    output logic       is_branch
);
    opcode_t o;
    assign o = opcode_t'(op);
    assign alu_op = (o == OP_SUB || o == OP_BEQ) ? ALU_SUB : o == OP_JMP ? ALU_PASS_B : ALU_ADD;
    assign is_mem = o == OP_LW || o == OP_SW;
    assign is_store = o == OP_SW;
    assign is_branch = o == OP_BEQ;
    assign alu_b_sel = o == OP_ADDI || is_mem;
    assign ext_sel = is_branch;
endmodule

// File: rtl/nrisc_control_fsm.sv
// nrisc_control_fsm: multi-cycle fetch/decode/execute/memory/write-back sequencer for the 8-bit nRisc core.
module nrisc_control_fsm
    import nrisc_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15,
    parameter int RET_W = 8
) (
    input logic clock,
    input logic reset,
    nrisc_control_fsm_if.master bus
);
    state_t state, state_n;
    logic [7:0] wait_q;
    logic [RET_W-1:0] retired_q;
    logic ack_q, req, acked, timeout;
    logic [1:0] dec_alu_op;
    logic dec_b_sel, dec_ext, is_mem, is_store, is_branch;
    opcode_t op;
    assign op = opcode_t'(bus.ir[7:5]);
    nrisc_op_decode u_dec (
        .op(bus.ir[7:5]),
        .alu_op(dec_alu_op),
        .alu_b_sel(dec_b_sel),
        .ext_sel(dec_ext),
        .is_mem(is_mem),
        .is_store(is_store),
        .is_branch(is_branch)
    );
    // ack_q blanks the request for one cycle after any ack, so SW data -> next fetch never runs back to back
    assign req = (state == S_FETCH || state == S_MEM) && !ack_q && !reset;
    assign acked = req && bus.mem_ack;
    assign timeout = req && !bus.mem_ack && wait_q == 8'(MEM_TIMEOUT - 1);
    assign bus.mem_req = req;
    assign bus.halted = state == S_HALT;
    assign bus.fault = state == S_FAULT;
    assign bus.retired = retired_q;
    always_comb begin
        state_n = state;
        bus.mem_we = 1'b0;
        bus.mem_src = 1'b0;
        bus.ir_write = 1'b0;
        bus.pc_write = 1'b0;
        bus.pc_src = PC_INC;
        bus.ext_sel = 1'b0;
        bus.alu_op = ALU_ADD;
        bus.alu_b_sel = 1'b0;
        bus.reg_write = 1'b0;
        bus.wb_src = 1'b0;
        if (!reset) begin
            case (state)
                S_FETCH: begin
                    bus.ir_write = acked;
                    bus.pc_write = acked;
                    state_n = acked ? S_DECODE : timeout ? S_FAULT : S_FETCH;
                end
                S_DECODE: begin
                    bus.pc_write = op == OP_JMP;
                    bus.pc_src = op == OP_JMP ? PC_JUMP : PC_INC;
                    state_n = op == OP_HALT ? S_HALT : op == OP_JMP ? S_FETCH : S_EXEC;
                end
                S_EXEC: begin
                    bus.alu_op = dec_alu_op;
                    bus.alu_b_sel = dec_b_sel;
                    bus.ext_sel = dec_ext;
                    bus.pc_write = is_branch && bus.zero;
                    bus.pc_src = is_branch && bus.zero ? PC_BRANCH : PC_INC;
                    state_n = is_mem ? S_MEM : is_branch ? S_FETCH : S_WB;
                end
                S_MEM: begin
                    bus.mem_src = 1'b1;
                    bus.mem_we = req && is_store;
                    state_n = acked ? (is_store ? S_FETCH : S_WB) : timeout ? S_FAULT : S_MEM;
                end
                S_WB: begin
                    bus.reg_write = 1'b1;
                    bus.wb_src = is_mem && !is_store;
                    state_n = S_FETCH;
                end
                default: ;
            endcase
        end
    end
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= S_FETCH;
            wait_q <= '0;
            ack_q <= 1'b0;
            retired_q <= '0;
        end else begin
            state <= state_n;
            wait_q <= state_n != state ? '0 : wait_q + 8'(req && !bus.mem_ack);
            ack_q <= acked;
            if (state_n == S_FETCH && state != S_FETCH) retired_q <= retired_q + RET_W'(1);
        end
    end
endmodule

// File: tb/tb_nrisc_control_fsm.sv
// tb_nrisc_control_fsm: directed-vector bench for the nRisc control unit.
module tb_nrisc_control_fsm;
    import nrisc_pkg::*;
    localparam logic [7:0] I_ADD = 8'b000_01_100;
    localparam logic [7:0] I_ADDI = 8'b010_01_101;
    localparam logic [7:0] I_LW = 8'b011_10_011;
    localparam logic [7:0] I_SW = 8'b100_01_010;
    localparam logic [7:0] I_BEQ = 8'b101_00_110;
    localparam logic [7:0] I_JMP = 8'b110_00_101;
    localparam logic [7:0] I_HALT = 8'hE0;
    logic clock = 1'b0;
    logic reset = 1'b1;
    logic seen;
    int checks = 0;
    int errors = 0;
    nrisc_control_fsm_if #(.RET_W(8)) bus ();
    nrisc_control_fsm #(.MEM_TIMEOUT(15), .RET_W(8)) dut (.clock(clock), .reset(reset), .bus(bus));
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic nxt();
        @(negedge clock);
        bus.mem_ack = 1'b0;
        bus.zero = 1'b0;
        #1;
    endtask

    task automatic ack_cycle();
        @(negedge clock);
        bus.mem_ack = 1'b1;
        #1;
    endtask

    task automatic fetch(input logic [7:0] v, input int d);
        repeat (d) begin
            nxt();
            chk("fetch_wait_req", 32'(bus.mem_req), 1);
        end
        @(negedge clock);
        bus.mem_ack = 1'b1;
        bus.ir = v;
        #1;
        chk("fetch_ack", 32'({bus.ir_write, bus.pc_write, bus.pc_src, bus.mem_src, bus.mem_we}), 6'b110000);
    endtask

    task automatic rel();
        @(posedge clock);
        #2 reset = 1'b0;
    endtask

    initial begin
        bus.ir = 8'h00;
        bus.zero = 1'b0;
        bus.mem_ack = 1'b1;
        repeat (2) @(negedge clock);
        #1;
        chk("rst_outputs", 32'({bus.mem_req, bus.ir_write, bus.pc_write, bus.halted, bus.fault}), 0);
        chk("rst_retired", 32'(bus.retired), 0);
        bus.mem_ack = 1'b0;
        rel();
        fetch(I_ADDI, 2);
        nxt();
        chk("addi_decode", 32'({bus.mem_req, bus.pc_write, bus.reg_write}), 0);
        nxt();
        chk("addi_exec", 32'({bus.alu_op, bus.alu_b_sel, bus.ext_sel, bus.reg_write}), 5'b00100);
        nxt();
        chk("addi_wb", 32'({bus.reg_write, bus.wb_src}), 2'b10);
        fetch(I_LW, 0);
        chk("ret_addi", 32'(bus.retired), 1);
        nxt();
        nxt();
        chk("lw_exec", 32'({bus.alu_op, bus.alu_b_sel, bus.ext_sel}), 4'b0010);
        ack_cycle();
        chk("lw_mem", 32'({bus.mem_req, bus.mem_src, bus.mem_we}), 3'b110);
        nxt();
        chk("lw_wb", 32'({bus.reg_write, bus.wb_src, bus.mem_req}), 3'b110);
        fetch(I_SW, 0);
        chk("ret_lw", 32'(bus.retired), 2);
        nxt();
        nxt();
        ack_cycle();
        chk("sw_mem", 32'({bus.mem_req, bus.mem_src, bus.mem_we}), 3'b111);
        nxt();
        chk("sw_gap", 32'({bus.mem_req, bus.reg_write}), 0);
        chk("ret_sw", 32'(bus.retired), 3);
        fetch(I_BEQ, 0);
        nxt();
        @(negedge clock);
        bus.mem_ack = 1'b0;
        bus.zero = 1'b1;
        #1;
        chk("beq_taken", 32'({bus.pc_write, bus.pc_src, bus.ext_sel, bus.alu_op, bus.alu_b_sel}), 7'b1011010);
        fetch(I_BEQ, 0);
        chk("ret_beq_t", 32'(bus.retired), 4);
        nxt();
        nxt();
        chk("beq_not_taken", 32'({bus.pc_write, bus.pc_src, bus.ext_sel, bus.alu_op, bus.alu_b_sel}), 7'b0001010);
        fetch(I_JMP, 0);
        chk("ret_beq_nt", 32'(bus.retired), 5);
        nxt();
        chk("jmp_decode", 32'({bus.pc_write, bus.pc_src, bus.ext_sel}), 4'b1100);
        fetch(I_ADD, 14);
        chk("ret_jmp", 32'(bus.retired), 6);
        nxt();
        chk("ack_at_limit", 32'({bus.fault, bus.mem_req}), 0);
        nxt();
        chk("add_exec", 32'({bus.alu_op, bus.alu_b_sel}), 0);
        nxt();
        chk("add_wb", 32'({bus.reg_write, bus.wb_src}), 2'b10);
        repeat (15) begin
            nxt();
            chk("timeout_wait_req", 32'({bus.mem_req, bus.fault}), 2'b10);
        end
        nxt();
        chk("timeout_fault", 32'({bus.fault, bus.mem_req}), 2'b10);
        chk("ret_add", 32'(bus.retired), 7);
        repeat (5) ack_cycle();
        chk("fault_absorb", 32'({bus.fault, bus.mem_req, bus.ir_write}), 3'b100);
        reset = 1'b1;
        #1;
        chk("fault_reset", 32'({bus.fault, bus.mem_req, bus.ir_write, bus.retired}), 0);
        bus.mem_ack = 1'b0;
        rel();
        fetch(I_ADDI, 0);
        repeat (3) nxt();
        fetch(I_LW, 0);
        chk("ret_after_reset", 32'(bus.retired), 1);
        repeat (3) nxt();
        chk("mem_pending", 32'({bus.mem_req, bus.mem_src}), 2'b11);
        #1 reset = 1'b1;
        #1;
        chk("reset_mid_mem", 32'({bus.mem_req, bus.reg_write, bus.mem_src, bus.retired}), 0);
        rel();
        fetch(I_HALT, 1);
        nxt();
        chk("halt_decode", 32'({bus.pc_write, bus.halted}), 0);
        nxt();
        chk("halted", 32'({bus.halted, bus.mem_req}), 2'b10);
        seen = 1'b0;
        repeat (20) begin
            ack_cycle();
            seen = seen | bus.mem_req | bus.ir_write | bus.reg_write | bus.pc_write;
        end
        chk("halt_quiet", 32'(seen), 0);
        chk("halt_sticky", 32'(bus.halted), 1);
        reset = 1'b1;
        #1;
        chk("halt_reset", 32'({bus.halted, bus.mem_req}), 0);
        bus.mem_ack = 1'b0;
        rel();
        for (int i = 0; i < 256; i++) begin
            fetch(I_ADD, 0);
            if (i == 255) chk("ret_max", 32'(bus.retired), 255);
            repeat (3) nxt();
        end
        fetch(I_ADD, 0);
        chk("ret_wrap", 32'(bus.retired), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
